// File: rtl/hazard_unit_sb.sv
// rtl/hazard_unit_sb.sv - RV32I hazard unit with load-use FSM, long-op scoreboard and stall counter
module hazard_unit_sb #(
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] Rs1D,
    input  logic [ADDR_W-1:0] Rs2D,
    input  logic [ADDR_W-1:0] Rs1E,
    input  logic [ADDR_W-1:0] Rs2E,
    input  logic [ADDR_W-1:0] RdE,
    input  logic [ADDR_W-1:0] RdM,
    input  logic [ADDR_W-1:0] RdW,
    input  logic              MemtoRegE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              PCSrcE,
    input  logic              LongIssueE,
    input  logic              LongOpD,
    input  logic              LongDone,
    input  logic [ADDR_W-1:0] LongRd,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [CNT_W-1:0]  StallCount
);

    typedef enum logic {IDLE, LDSTALL} ld_state_t;

    localparam logic [1:0] LD_INIT = 2'(LOAD_LAT - 1);

    ld_state_t           state;
    logic [1:0]          ld_cnt;
    logic [NUM_REGS-1:0] busy;
    logic                long_pend;

    logic       ld_entry, ld_stall, sb_stall, stall, stall_f, flush_e, issue;
    logic       busy_a, busy_b;
    logic [1:0] fwd_a, fwd_b;

    always_comb begin
        ld_entry = (state == IDLE) && MemtoRegE && (RdE != '0)
                   && ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;
        ld_stall = ld_entry || ((state == LDSTALL) && (ld_cnt != 2'd0));

        // A register whose long result lands this cycle is readable through the bypass.
        busy_a   = busy[Rs1D] && (Rs1D != '0) && !(LongDone && (LongRd == Rs1D));
        busy_b   = busy[Rs2D] && (Rs2D != '0) && !(LongDone && (LongRd == Rs2D));
        sb_stall = busy_a || busy_b || (LongOpD && long_pend && !LongDone);

        stall    = ld_stall || sb_stall;
        stall_f  = stall && !PCSrcE;
        flush_e  = stall || PCSrcE;
        issue    = LongIssueE && !flush_e;

        fwd_a = 2'b00;
        if (Rs1E != '0) begin
            if (LongDone && (LongRd == Rs1E))      fwd_a = 2'b11;
            else if (RegWriteM && (RdM == Rs1E))   fwd_a = 2'b01;
            else if (RegWriteW && (RdW == Rs1E))   fwd_a = 2'b10;
        end
        fwd_b = 2'b00;
        if (Rs2E != '0) begin
            if (LongDone && (LongRd == Rs2E))      fwd_b = 2'b11;
            else if (RegWriteM && (RdM == Rs2E))   fwd_b = 2'b01;
            else if (RegWriteW && (RdW == Rs2E))   fwd_b = 2'b10;
        end
    end

    // Outputs are forced low while reset is held so the pipeline sees no stale control.
    assign StallF    = rst_n && stall_f;
    assign StallD    = rst_n && stall_f;
    assign FlushD    = rst_n && PCSrcE;
    assign FlushE    = rst_n && flush_e;
    assign ForwardAE = rst_n ? fwd_a : 2'b00;
    assign ForwardBE = rst_n ? fwd_b : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ld_cnt     <= 2'd0;
            busy       <= '0;
            long_pend  <= 1'b0;
            StallCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_entry) begin
                        state  <= LDSTALL;
                        ld_cnt <= LD_INIT;
                    end
                end
                LDSTALL: begin
                    if (ld_cnt == 2'd0) state <= IDLE;
                    else                ld_cnt <= ld_cnt - 2'd1;
                end
                default: state <= IDLE;
            endcase

            // Clear first, set last: a newer issue to the same register wins.
            if (LongDone) begin
                busy[LongRd] <= 1'b0;
                long_pend    <= 1'b0;
            end
            if (issue) begin
                long_pend <= 1'b1;
                if (RdE != '0) busy[RdE] <= 1'b1;
            end

            if (stall_f && (StallCount != '1))
                StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit_sb.sv
// tb/tb_hazard_unit_sb.sv - self-checking bench for hazard_unit_sb against a behavioural model
module tb_hazard_unit_sb;

    localparam int LAT  = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, long_rd;
    logic mem_to_reg_e, reg_write_m, reg_write_w, pc_src_e, long_issue_e, long_op_d, long_done;
    logic stall_f, stall_d, flush_d, flush_e;
    logic [1:0] fwd_ae, fwd_be;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    bit busy_m [32];
    bit pend_m;
    int ld_window;
    int cnt_m;

    always #5 clk = ~clk;

    hazard_unit_sb #(.ADDR_W(5), .NUM_REGS(32), .LOAD_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(rs1_d), .Rs2D(rs2_d), .Rs1E(rs1_e), .Rs2E(rs2_e),
        .RdE(rd_e), .RdM(rd_m), .RdW(rd_w),
        .MemtoRegE(mem_to_reg_e), .RegWriteM(reg_write_m), .RegWriteW(reg_write_w),
        .PCSrcE(pc_src_e), .LongIssueE(long_issue_e), .LongOpD(long_op_d),
        .LongDone(long_done), .LongRd(long_rd),
        .StallF(stall_f), .StallD(stall_d), .FlushD(flush_d), .FlushE(flush_e),
        .ForwardAE(fwd_ae), .ForwardBE(fwd_be), .StallCount(stall_count)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, long_rd} = '0;
        {mem_to_reg_e, reg_write_m, reg_write_w, pc_src_e, long_issue_e, long_op_d, long_done} = '0;
    endtask

    task automatic model_reset();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        pend_m = 1'b0;
        ld_window = 0;
        cnt_m = 0;
    endtask

    function automatic int fwd_m(input logic [4:0] rs);
        if (rs == 0) return 0;
        if (long_done && long_rd == rs) return 3;
        if (reg_write_m && rd_m == rs) return 1;
        if (reg_write_w && rd_w == rs) return 2;
        return 0;
    endfunction

    // Called at the negedge: compares every output, then advances the model across the coming edge.
    task automatic eval_cycle();
        bit entry, ls, ss, st, sf, fe, iss;
        entry = mem_to_reg_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d) && !pc_src_e;
        ls = (ld_window > 0) ? (ld_window > 1) : entry;
        ss = (busy_m[rs1_d] && rs1_d != 0 && !(long_done && long_rd == rs1_d))
          || (busy_m[rs2_d] && rs2_d != 0 && !(long_done && long_rd == rs2_d))
          || (long_op_d && pend_m && !long_done);
        st = ls || ss;
        sf = st && !pc_src_e;
        fe = st || pc_src_e;
        check_val("stall_f", 32'(stall_f), 32'(sf));
        check_val("stall_d", 32'(stall_d), 32'(sf));
        check_val("flush_d", 32'(flush_d), 32'(pc_src_e));
        check_val("flush_e", 32'(flush_e), 32'(fe));
        check_val("fwd_a", 32'(fwd_ae), fwd_m(rs1_e));
        check_val("fwd_b", 32'(fwd_be), fwd_m(rs2_e));
        check_val("stall_count", 32'(stall_count), cnt_m);

        if (ld_window > 0) ld_window--;
        else if (entry) ld_window = LAT;
        iss = long_issue_e && !fe;
        if (long_done) begin
            busy_m[long_rd] = 1'b0;
            pend_m = 1'b0;
        end
        if (iss) begin
            pend_m = 1'b1;
            if (rd_e != 0) busy_m[rd_e] = 1'b1;
        end
        if (sf && cnt_m < CMAX) cnt_m++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycle();
        @(negedge clk);
        eval_cycle();
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        clear_inputs();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        @(negedge clk);
        check_val("reset_stall_f", 32'(stall_f), 0);
        check_val("reset_count", 32'(stall_count), 0);
        #2 rst_n = 1'b1;
        tick();

        // Load-use with LOAD_LAT=2: two stall cycles then release.
        mem_to_reg_e = 1; rd_e = 5; rs1_d = 6; rs2_d = 5;
        @(negedge clk); check_val("lu_stall1", 32'(stall_f), 1); eval_cycle(); tick();
        mem_to_reg_e = 0; rd_e = 0;
        @(negedge clk); check_val("lu_stall2", 32'(flush_e), 1); eval_cycle(); tick();
        @(negedge clk); check_val("lu_release", 32'(stall_d), 0);
        check_val("lu_count", 32'(stall_count), 2); eval_cycle(); tick();
        clear_inputs();

        // Forwarding priority and x0.
        reg_write_m = 1; rd_m = 7; reg_write_w = 1; rd_w = 7; rs1_e = 7;
        @(negedge clk); check_val("fwd_m_over_w", 32'(fwd_ae), 1); eval_cycle(); tick();
        rs1_e = 0; rd_m = 0;
        @(negedge clk); check_val("fwd_x0", 32'(fwd_ae), 0); eval_cycle(); tick();
        clear_inputs();

        // Long op on x9: reader stalls until completion, then bypasses the long result.
        long_issue_e = 1; rd_e = 9;
        run_cycle();
        clear_inputs(); rs1_d = 9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check_val("sb_wait", 32'(stall_f), 1); eval_cycle(); tick();
        end
        long_done = 1; long_rd = 9;
        @(negedge clk); check_val("sb_done", 32'(stall_f), 0); eval_cycle(); tick();
        rs1_d = 0; rs1_e = 9;
        @(negedge clk); check_val("sb_fwd_long", 32'(fwd_ae), 3); eval_cycle(); tick();
        clear_inputs();

        // Load-use coincident with redirect: flush wins and no load stall follows.
        mem_to_reg_e = 1; rd_e = 5; rs1_d = 5; pc_src_e = 1;
        @(negedge clk);
        check_val("br_flush_d", 32'(flush_d), 1);
        check_val("br_flush_e", 32'(flush_e), 1);
        check_val("br_stall_f", 32'(stall_f), 0);
        eval_cycle(); tick();
        clear_inputs(); rs1_d = 5;
        @(negedge clk); check_val("br_fsm_idle", 32'(stall_f), 0); eval_cycle(); tick();
        clear_inputs();

        // Reset mid-LDSTALL with x9 busy.
        long_issue_e = 1; rd_e = 9;
        run_cycle();
        clear_inputs(); mem_to_reg_e = 1; rd_e = 5; rs1_d = 5;
        run_cycle();
        clear_inputs(); rs1_d = 5; rs2_d = 9; reg_write_m = 1; rd_m = 7; rs1_e = 7; pc_src_e = 1;
        @(negedge clk);
        eval_cycle();
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_stall_f", 32'(stall_f), 0);
        check_val("rst_flush_d", 32'(flush_d), 0);
        check_val("rst_flush_e", 32'(flush_e), 0);
        check_val("rst_fwd_a", 32'(fwd_ae), 0);
        check_val("rst_count", 32'(stall_count), 0);
        model_reset();
        clear_inputs();
        tick();
        rst_n = 1'b1;
        rs1_d = 9;
        @(negedge clk); check_val("rst_busy_gone", 32'(stall_f), 0); eval_cycle(); tick();
        clear_inputs();

        // Saturation: 2**CW+3 stall cycles on a register that never completes.
        long_issue_e = 1; rd_e = 9;
        run_cycle();
        clear_inputs(); rs1_d = 9;
        for (int i = 0; i < (1 << CW) + 3; i++) run_cycle();
        @(negedge clk); check_val("sat_count", 32'(stall_count), CMAX); eval_cycle(); tick();
        do_reset();

        // Randomised traffic on a small register window to provoke hits.
        for (int i = 0; i < 800; i++) begin
            if (i % 200 == 199) do_reset();
            rs1_d = 5'($urandom_range(0, 3));
            rs2_d = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3));
            rs2_e = 5'($urandom_range(0, 3));
            rd_e  = 5'($urandom_range(0, 3));
            rd_m  = 5'($urandom_range(0, 3));
            rd_w  = 5'($urandom_range(0, 3));
            long_rd = 5'($urandom_range(0, 3));
            mem_to_reg_e = ($urandom_range(0, 2) == 0);
            reg_write_m  = $urandom_range(0, 1) == 1;
            reg_write_w  = $urandom_range(0, 1) == 1;
            pc_src_e     = ($urandom_range(0, 7) == 0);
            long_issue_e = ($urandom_range(0, 3) == 0);
            long_op_d    = ($urandom_range(0, 3) == 0);
            long_done    = ($urandom_range(0, 3) == 0);
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
